serial_paralelo_n: RTL and testbench

SERIAL_PARALELO_N -- requirements
Module: serial_paralelo_n

---
 rtl/serial_paralelo_n.sv | 182 ++++++++++++++++++
 tb/tb_serial_paralelo_n.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_n.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_n
// Description : Serial-to-parallel word deframer with comma alignment.
//               A free-running shift register collects the MSB-first bit
//               stream. The block hunts for a COMMA at any bit phase, then
//               has to see SYNC_COUNT commas on consecutive word boundaries
//               before it locks. While locked, each non-comma word is
//               delivered on data_out with a one-cycle valid_out pulse.
//               Commas are framing only and are never delivered. A run of
//               more than MAX_RUN data words without a comma drops the lock.
//
// Ports       : clk_32f   - serial bit clock (the only clock)
//               reset     - asynchronous active-low reset
//               data_in   - serial bit stream, MSB of each word first
//               active    - high while locked
//               valid_out - one-cycle pulse per delivered data word
//               data_out  - last delivered data word (held otherwise)
//               lock_lost - one-cycle pulse when the lock drops on a run
//                           violation
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_n #(
    parameter int unsigned       WIDTH      = 8,
    parameter logic [WIDTH-1:0]  COMMA      = 8'hBC,
    parameter int unsigned       SYNC_COUNT = 4,
    parameter int unsigned       MAX_RUN    = 16
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic             active,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             lock_lost
);

    // ------------------------------------------------------------------------
    // Counter sizing. Each counter is exactly wide enough for its terminal
    // value. When loss detection is disabled, the run counter keeps a
    // one-bit width and saturates at 1, so it stays legal but is never used
    // to make a decision.
    // ------------------------------------------------------------------------
    localparam int unsigned c_BIT_W   = $clog2(WIDTH);
    localparam int unsigned c_SYNC_W  = $clog2(SYNC_COUNT + 1);
    localparam int unsigned c_RUN_TOP = (MAX_RUN == 0) ? 1 : MAX_RUN;
    localparam int unsigned c_RUN_W   = $clog2(c_RUN_TOP + 1);
    localparam bit          c_LOSS_EN = (MAX_RUN != 0);

    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WIDTH - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [c_SYNC_W-1:0] c_SYNC_ONE  = c_SYNC_W'(1);
    localparam logic [c_SYNC_W-1:0] c_SYNC_LAST = c_SYNC_W'(SYNC_COUNT);
    localparam logic [c_RUN_W-1:0]  c_RUN_LIMIT = c_RUN_W'(c_RUN_TOP);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_sr;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_SYNC_W-1:0] r_comma_cnt;
    logic [c_RUN_W-1:0]  r_run_cnt;
    logic                r_active;
    logic                r_valid;
    logic [WIDTH-1:0]    r_data;
    logic                r_lost;

    logic                w_comma;
    logic                w_boundary;
    logic [c_BIT_W-1:0]  w_bit_next;
    logic [c_SYNC_W-1:0] w_comma_inc;
    logic                w_run_full;

    // All decisions look at the word already held in r_sr. The bit that is
    // sampled on the same edge only becomes visible on the next cycle.
    assign w_comma     = (r_sr == COMMA);
    assign w_boundary  = (r_bit_cnt == '0);
    assign w_bit_next  = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    assign w_comma_inc = r_comma_cnt + 1'b1;
    assign w_run_full  = (r_run_cnt == c_RUN_LIMIT);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HUNT;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_comma_cnt <= '0;
            r_run_cnt   <= '0;
            r_active    <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_lost      <= 1'b0;
        end else begin
            r_sr    <= {r_sr[WIDTH-2:0], data_in};
            r_valid <= 1'b0;
            r_lost  <= 1'b0;

            case (r_state)
                ST_HUNT: begin
                    r_bit_cnt <= '0;
                    if (w_comma) begin
                        // The comma has just completed, so the next word
                        // begins with the bit sampled on this edge. Loading 1
                        // puts the next boundary WIDTH cycles from now.
                        r_bit_cnt   <= c_BIT_ONE;
                        r_comma_cnt <= c_SYNC_ONE;
                        if (SYNC_COUNT == 1) begin
                            r_state   <= ST_LOCKED;
                            r_run_cnt <= '0;
                            r_active  <= 1'b1;
                        end else begin
                            r_state <= ST_ALIGN;
                        end
                    end
                end

                ST_ALIGN: begin
                    r_bit_cnt <= w_bit_next;
                    if (w_boundary) begin
                        if (w_comma) begin
                            r_comma_cnt <= w_comma_inc;
                            if (w_comma_inc == c_SYNC_LAST) begin
                                r_state   <= ST_LOCKED;
                                r_run_cnt <= '0;
                                r_active  <= 1'b1;
                            end
                        end else begin
                            r_state     <= ST_HUNT;
                            r_comma_cnt <= '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    r_bit_cnt <= w_bit_next;
                    if (w_boundary) begin
                        if (w_comma) begin
                            // A comma confirms the framing. It restarts the
                            // run count and is not delivered.
                            r_run_cnt <= '0;
                        end else if (!c_LOSS_EN || !w_run_full) begin
                            r_data  <= r_sr;
                            r_valid <= 1'b1;
                            if (!w_run_full) begin
                                r_run_cnt <= r_run_cnt + 1'b1;
                            end
                        end else begin
                            // The run limit is exceeded. Drop this word,
                            // keep data_out at the last delivered value,
                            // and hunt again.
                            r_lost      <= 1'b1;
                            r_active    <= 1'b0;
                            r_state     <= ST_HUNT;
                            r_comma_cnt <= '0;
                            r_run_cnt   <= '0;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_HUNT;
                    r_bit_cnt   <= '0;
                    r_comma_cnt <= '0;
                    r_run_cnt   <= '0;
                    r_active    <= 1'b0;
                end
            endcase
        end
    end

    assign active    = r_active;
    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign lock_lost = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_paralelo_n
// Description : Directed self-checking bench for serial_paralelo_n.
//               Instance a uses the defaults, instance b uses MAX_RUN=2, and
//               instance c uses a 10-bit word with a single-comma lock.
//               Only one instance is driven at a time. A negedge monitor
//               records delivered words, delivery cycles, active rises and
//               lock_lost pulses for the selected instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_n;

    logic clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    logic       rst_a, rst_b, rst_c;
    logic       din_a, din_b, din_c;
    logic       act_a, act_b, act_c;
    logic       vld_a, vld_b, vld_c;
    logic       lost_a, lost_b, lost_c;
    logic [7:0] dout_a, dout_b;
    logic [9:0] dout_c;

    serial_paralelo_n u_dut_a (
        .clk_32f   (clk_32f),
        .reset     (rst_a),
        .data_in   (din_a),
        .active    (act_a),
        .valid_out (vld_a),
        .data_out  (dout_a),
        .lock_lost (lost_a)
    );

    serial_paralelo_n #(.MAX_RUN(2)) u_dut_b (
        .clk_32f   (clk_32f),
        .reset     (rst_b),
        .data_in   (din_b),
        .active    (act_b),
        .valid_out (vld_b),
        .data_out  (dout_b),
        .lock_lost (lost_b)
    );

    serial_paralelo_n #(.WIDTH(10), .COMMA(10'h17C), .SYNC_COUNT(1)) u_dut_c (
        .clk_32f   (clk_32f),
        .reset     (rst_c),
        .data_in   (din_c),
        .active    (act_c),
        .valid_out (vld_c),
        .data_out  (dout_c),
        .lock_lost (lost_c)
    );

    // ------------------------------------------------------------------
    // Monitor on the selected instance.
    // ------------------------------------------------------------------
    int          mon_sel = 0;
    logic [31:0] sel_dout;
    logic        sel_vld, sel_act, sel_lost;

    always_comb begin
        sel_dout = 32'd0;
        sel_vld  = 1'b0;
        sel_act  = 1'b0;
        sel_lost = 1'b0;
        case (mon_sel)
            0: begin
                sel_dout = {24'd0, dout_a};
                sel_vld  = vld_a;
                sel_act  = act_a;
                sel_lost = lost_a;
            end
            1: begin
                sel_dout = {24'd0, dout_b};
                sel_vld  = vld_b;
                sel_act  = act_b;
                sel_lost = lost_b;
            end
            default: begin
                sel_dout = {22'd0, dout_c};
                sel_vld  = vld_c;
                sel_act  = act_c;
                sel_lost = lost_c;
            end
        endcase
    end

    int          cyc = 0;
    int          last_edge = 0;
    logic [31:0] got_w[$];
    int          got_c[$];
    logic [31:0] exp_w[$];
    int          exp_c[$];
    int          rises = 0;
    int          rise_cyc = -1;
    int          lost_n = 0;
    int          bad_vld = 0;
    logic        act_prev = 1'b0;

    always @(posedge clk_32f) cyc = cyc + 1;

    always @(negedge clk_32f) begin
        if (sel_vld) begin
            got_w.push_back(sel_dout);
            got_c.push_back(cyc);
        end
        if (sel_lost) lost_n++;
        if (sel_act && !act_prev) begin
            rises++;
            rise_cyc = cyc;
        end
        act_prev = sel_act;
        if ((vld_a && !act_a) || (vld_b && !act_b) || (vld_c && !act_c)) bad_vld++;
    end

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive nb bits of w, MSB first, one bit per negedge. last_edge is the
    // posedge number that samples the final bit.
    task automatic send(input int sel, input logic [31:0] w, input int nb);
        for (int i = nb - 1; i >= 0; i--) begin
            @(negedge clk_32f);
            case (sel)
                0:       din_a = w[i];
                1:       din_b = w[i];
                default: din_c = w[i];
            endcase
        end
        last_edge = cyc + 1;
    endtask

    // Send a data word and record its expected delivery, one edge after the
    // edge that samples its last bit.
    task automatic send_data(input int sel, input logic [31:0] w, input int nb);
        send(sel, w, nb);
        exp_w.push_back(w);
        exp_c.push_back(last_edge + 1);
    endtask

    task automatic begin_test(input int sel);
        @(posedge clk_32f);
        #2;
        got_w.delete();
        got_c.delete();
        exp_w.delete();
        exp_c.delete();
        rises    = 0;
        rise_cyc = -1;
        lost_n   = 0;
        act_prev = 1'b0;
        mon_sel  = sel;
    endtask

    task automatic check_words(input string tag);
        check_eq({tag, "_count"}, got_w.size(), exp_w.size());
        foreach (exp_w[i]) begin
            check_eq($sformatf("%s_word%0d", tag, i),
                     (i < got_w.size()) ? got_w[i] : 32'hDEAD_BEEF, exp_w[i]);
            check_eq($sformatf("%s_cycle%0d", tag, i),
                     (i < got_c.size()) ? got_c[i] : -1, exp_c[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int e_lock;

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        din_a = 1'b0;
        din_b = 1'b0;
        din_c = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_32f);
        #1;
        check_eq("rst_active",    act_a,  1'b0);
        check_eq("rst_valid",     vld_a,  1'b0);
        check_eq("rst_data_out",  dout_a, 8'h00);
        check_eq("rst_lock_lost", lost_a, 1'b0);
        check_eq("rst_b_data",    dout_b, 8'h00);
        check_eq("rst_c_data",    dout_c, 10'h000);

        // Defaults: 3 stray bits, 4x BC, then 5A and 3C
        begin_test(0);
        rst_a = 1'b1;
        send(0, 32'b101, 3);
        repeat (4) send(0, 32'hBC, 8);
        e_lock = last_edge;
        send_data(0, 32'h5A, 8);
        send_data(0, 32'h3C, 8);
        send(0, 32'b101, 3);
        #1;
        check_eq("lock_rises",   rises, 1);
        check_eq("lock_cycle",   rise_cyc, e_lock + 1);
        check_words("basic");
        check_eq("basic_active", act_a, 1'b1);
        check_eq("basic_hold",   dout_a, 8'h3C);

        // Asynchronous reset mid-word while locked, without any clock edge
        rst_a = 1'b0;
        #1;
        check_eq("async_active", act_a,  1'b0);
        check_eq("async_valid",  vld_a,  1'b0);
        check_eq("async_data",   dout_a, 8'h00);
        check_eq("async_lost",   lost_a, 1'b0);

        // 3x BC then 11 must fall back to HUNT. Only the later 4 BCs lock.
        begin_test(0);
        rst_a = 1'b1;
        repeat (3) send(0, 32'hBC, 8);
        send(0, 32'h11, 8);
        repeat (4) send(0, 32'hBC, 8);
        e_lock = last_edge;
        send_data(0, 32'h66, 8);
        send(0, 32'h0, 2);
        #1;
        check_eq("relock_rises", rises, 1);
        check_eq("relock_cycle", rise_cyc, e_lock + 1);
        check_words("relock");
        rst_a = 1'b0;

        // MAX_RUN=2: a BC clears the run, then 01 and 02 pass and 03 drops
        // the lock
        begin_test(1);
        rst_b = 1'b1;
        repeat (4) send(1, 32'hBC, 8);
        send_data(1, 32'h11, 8);
        send_data(1, 32'h22, 8);
        send(1, 32'hBC, 8);
        send_data(1, 32'h01, 8);
        send_data(1, 32'h02, 8);
        send(1, 32'h03, 8);
        send(1, 32'h0, 2);
        #1;
        check_eq("run_lost_pulse", lost_b, 1'b1);
        check_eq("run_active",     act_b,  1'b0);
        check_eq("run_hold",       dout_b, 8'h02);
        @(negedge clk_32f);
        #1;
        check_eq("run_lost_end",   lost_b, 1'b0);
        check_eq("run_hold2",      dout_b, 8'h02);
        check_eq("run_lost_count", lost_n, 1);
        check_words("run");

        // 10-bit word, comma 17C, lock on the first comma
        begin_test(2);
        rst_c = 1'b1;
        send(2, 32'h17C, 10);
        e_lock = last_edge;
        send_data(2, 32'h2A5, 10);
        send_data(2, 32'h0F3, 10);
        send(2, 32'h0, 2);
        #1;
        check_eq("w10_rises",  rises, 1);
        check_eq("w10_cycle",  rise_cyc, e_lock + 1);
        check_words("w10");
        check_eq("w10_active", act_c, 1'b1);

        check_eq("valid_without_active", bad_vld, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
